// File: rtl/umai_mem_slave.sv
// umai_mem_slave: memory-backed UMAI slave, Depth x 512-bit word store.
// Ports: i_clk/i_rst (sync, active-high); wcmd and rcmd command handshakes
// (addr, len = beats-1); wvalid/wready/wdata write beats; rvalid/rready/rdata
// read beats. Define UMAI_MEM_PERF_EN to add o_wbeat_cnt / o_rbeat_cnt.
module umai_mem_slave #(
  parameter int Depth = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wcmd_valid,
  output logic         o_wcmd_ready,
  input  logic [31:0]  i_wcmd_addr,
  input  logic [5:0]   i_wcmd_len,
  input  logic         i_rcmd_valid,
  output logic         o_rcmd_ready,
  input  logic [31:0]  i_rcmd_addr,
  input  logic [5:0]   i_rcmd_len,
  input  logic         i_wvalid,
  output logic         o_wready,
  input  logic [511:0] i_wdata,
  output logic         o_rvalid,
  input  logic         i_rready,
  output logic [511:0] o_rdata
`ifdef UMAI_MEM_PERF_EN
  ,
  output logic [31:0]  o_wbeat_cnt,
  output logic [31:0]  o_rbeat_cnt
`endif
);

  localparam int AW = $clog2(Depth);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_wr;
  logic [AW-1:0] idx;
  // write: beats still to accept; read: beats still to load
  logic [6:0]    cnt;
  logic [511:0]  mem [Depth];

  logic grant_w;
  logic grant_r;
  logic wbeat;
  logic rload;
  logic rhs;

  assign grant_w = i_wcmd_valid &&
                   (!i_rcmd_valid || !last_wr);
  assign grant_r = i_rcmd_valid &&
                   (!i_wcmd_valid || last_wr);

  assign wbeat = (state == WRITE) && i_wvalid;
  assign rhs   = o_rvalid && i_rready;
  // refill the output register whenever it is empty or draining
  assign rload = (state == READ) &&
                 (!o_rvalid || i_rready) &&
                 (cnt != 7'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    o_wcmd_ready = 1'b0;
    o_rcmd_ready = 1'b0;
    o_wready     = 1'b0;
    unique case (state)
      IDLE: begin
        o_wcmd_ready = grant_w;
        o_rcmd_ready = grant_r;
        if (grant_w) begin
          state_nxt = WRITE;
        end else if (grant_r) begin
          state_nxt = READ;
        end
      end
      WRITE: begin
        o_wready = 1'b1;
        if (i_wvalid && cnt == 7'd1) begin
          state_nxt = IDLE;
        end
      end
      READ: begin
        // last beat: nothing left to load and final beat taken
        if (rhs && cnt == 7'd0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_wr  <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end else begin
      if (state == IDLE) begin
        if (grant_w) begin
          idx     <= i_wcmd_addr[6 +: AW];
          cnt     <= {1'b0, i_wcmd_len} + 7'd1;
          last_wr <= 1'b1;
        end else if (grant_r) begin
          idx     <= i_rcmd_addr[6 +: AW];
          cnt     <= {1'b0, i_rcmd_len} + 7'd1;
          last_wr <= 1'b0;
        end
      end
      if (wbeat || rload) begin
        idx <= idx + AW'(1);
        cnt <= cnt - 7'd1;
      end
      if (rload) begin
        o_rdata  <= mem[idx];
        o_rvalid <= 1'b1;
      end else if (rhs) begin
        o_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wbeat && !i_rst) begin
      mem[idx] <= i_wdata;
    end
  end

`ifdef UMAI_MEM_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wbeat_cnt <= '0;
      o_rbeat_cnt <= '0;
    end else begin
      if (wbeat) begin
        o_wbeat_cnt <= o_wbeat_cnt + 32'd1;
      end
      if (rhs) begin
        o_rbeat_cnt <= o_rbeat_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
